// File: rtl/tdm_mux4.sv
// rtl/tdm_mux4.sv - 4-lane round-robin time-division multiplexer
// Gathers four valid/ready lanes onto one registered, lane-tagged output beat.
module tdm_mux4 #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic [3:0]         in_valid,
   input  logic [4*WIDTH-1:0] in_data,
   output logic [3:0]         in_ready,
   output logic               out_valid,
   output logic [WIDTH-1:0]   out_data,
   output logic [1:0]         out_sel,
   input  logic               out_ready
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [1:0]       out_sel_q, out_sel_d;
   logic [1:0]       last_grant_q, last_grant_d;

   logic             load;
   logic             found;
   logic [1:0]       grant;
   logic [1:0]       idx;

   // Search starts one past the last winner, so the previous winner is tried last.
   always_comb begin
      grant = last_grant_q;
      found = 1'b0;
      idx   = 2'd0;
      for (int k = 1; k <= 4; k++) begin
         idx = last_grant_q + 2'(k);
         if (!found && in_valid[idx]) begin
            grant = idx;
            found = 1'b1;
         end
      end
   end

   // rst_n is folded in so no lane sees a handshake while the block is held in reset.
   assign load = rst_n & en & found & ((state_q == EMPTY) | out_ready);

   always_comb begin
      in_ready = 4'b0000;
      if (load) begin
         in_ready[grant] = 1'b1;
      end
   end

   always_comb begin
      state_d      = state_q;
      out_data_d   = out_data_q;
      out_sel_d    = out_sel_q;
      last_grant_d = last_grant_q;
      if (load) begin
         state_d      = FULL;
         out_data_d   = in_data[grant*WIDTH +: WIDTH];
         out_sel_d    = grant;
         last_grant_d = grant;
      end else if ((state_q == FULL) && out_ready) begin
         state_d = EMPTY;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= EMPTY;
         out_data_q   <= '0;
         out_sel_q    <= 2'd0;
         last_grant_q <= 2'd3;
      end else begin
         state_q      <= state_d;
         out_data_q   <= out_data_d;
         out_sel_q    <= out_sel_d;
         last_grant_q <= last_grant_d;
      end
   end

   assign out_valid = (state_q == FULL);
   assign out_data  = out_data_q;
   assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_tdm_mux4.sv
// tb/tb_tdm_mux4.sv - self-checking bench for tdm_mux4
// Behavioural model checked every negedge, plus directed literal expectations.
module tb_tdm_mux4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic [3:0]  in_valid;
   logic [31:0] in_data;
   logic [3:0]  in_ready;
   logic        out_valid;
   logic [7:0]  out_data;
   logic [1:0]  out_sel;
   logic        out_ready;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   tdm_mux4 #(.WIDTH(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .out_valid(out_valid),
      .out_data (out_data),
      .out_sel  (out_sel),
      .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   // Model state
   logic       m_valid;
   logic [7:0] m_data;
   logic [1:0] m_sel;
   logic [1:0] m_last;

   function automatic int model_lane();
      if (!rst_n || !en || in_valid == 4'b0000 || (m_valid && !out_ready)) return -1;
      for (int k = 1; k <= 4; k++) begin
         int lane;
         lane = (int'(m_last) + k) % 4;
         if (in_valid[lane]) return lane;
      end
      return -1;
   endfunction

   function automatic logic [3:0] model_ready();
      int lane;
      lane = model_lane();
      if (lane < 0) return 4'b0000;
      return 4'b0001 << lane;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid = 1'b0;
         m_data  = 8'h00;
         m_sel   = 2'd0;
         m_last  = 2'd3;
      end else begin
         int lane;
         lane = model_lane();
         if (lane >= 0) begin
            m_valid = 1'b1;
            m_data  = in_data[lane*8 +: 8];
            m_sel   = 2'(lane);
            m_last  = 2'(lane);
         end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("mdl_out_valid", 32'(out_valid), 32'(m_valid));
         check("mdl_out_data",  32'(out_data),  32'(m_data));
         check("mdl_out_sel",   32'(out_sel),   32'(m_sel));
         check("mdl_in_ready",  32'(in_ready),  32'(model_ready()));
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_lanes(input logic [7:0] d0, input logic [7:0] d1,
                            input logic [7:0] d2, input logic [7:0] d3);
      in_data = {d3, d2, d1, d0};
   endtask

   initial begin
      rst_n     = 1'b0;
      en        = 1'b1;
      in_valid  = 4'b1111;
      out_ready = 1'b1;
      set_lanes(8'h11, 8'h22, 8'h33, 8'h44);
      #1;
      chk_en = 1'b1;

      // Reset state with arbitrary active inputs
      cyc();
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data",  32'(out_data),  32'h00);
      check("rst_out_sel",   32'(out_sel),   32'd0);
      check("rst_in_ready",  32'(in_ready),  32'b0000);
      rst_n = 1'b1;
      #1;
      check("post_rst_in_ready", 32'(in_ready), 32'b0001);

      // Round robin, all lanes valid
      set_lanes(8'hA0, 8'hA1, 8'hA2, 8'hA3);
      #1;
      for (int k = 0; k < 5; k++) begin
         cyc();
         check("rr_valid", 32'(out_valid), 32'd1);
         check("rr_sel",   32'(out_sel),   32'(k % 4));
         check("rr_data",  32'(out_data),  32'(8'hA0 + 8'(k % 4)));
      end

      // Sparse requesters: establish last_grant=1, then lanes 1 and 3
      in_valid = 4'b0010;
      cyc();
      check("sp_sel_1", 32'(out_sel), 32'd1);
      in_valid = 4'b1010;
      cyc();
      check("sp_sel_3", 32'(out_sel), 32'd3);
      cyc();
      check("sp_sel_1b", 32'(out_sel), 32'd1);
      in_valid = 4'b0110;
      cyc();
      check("sp_sel_2", 32'(out_sel), 32'd2);

      // Backpressure with 0x55 held from lane 2
      set_lanes(8'hB0, 8'hB1, 8'h55, 8'hB3);
      in_valid = 4'b0100;
      cyc();
      check("bp_load_sel",  32'(out_sel),  32'd2);
      check("bp_load_data", 32'(out_data), 32'h55);
      out_ready = 1'b0;
      in_valid  = 4'b1111;
      for (int k = 0; k < 3; k++) begin
         cyc();
         check("bp_hold_data",  32'(out_data),  32'h55);
         check("bp_hold_sel",   32'(out_sel),   32'd2);
         check("bp_hold_valid", 32'(out_valid), 32'd1);
         check("bp_hold_ready", 32'(in_ready),  32'b0000);
      end
      out_ready = 1'b1;
      #1;
      check("bp_release_ready", 32'(in_ready), 32'b1000);
      cyc();
      check("bp_release_sel",  32'(out_sel),  32'd3);
      check("bp_release_data", 32'(out_data), 32'hB3);

      // Enable low drains the held beat and blocks grants
      en = 1'b0;
      #1;
      check("en_ready_off", 32'(in_ready), 32'b0000);
      cyc();
      check("en_drained", 32'(out_valid), 32'd0);
      check("en_sel_hold", 32'(out_sel), 32'd3);
      cyc();
      check("en_still_empty", 32'(out_valid), 32'd0);
      en = 1'b1;
      cyc();
      check("en_resume_sel",  32'(out_sel),  32'd0);
      check("en_resume_data", 32'(out_data), 32'hB0);

      // Asynchronous reset in the middle of a stall
      out_ready = 1'b0;
      cyc();
      check("ar_stalled", 32'(out_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_valid_drop", 32'(out_valid), 32'd0);
      check("ar_sel_clear",  32'(out_sel),   32'd0);
      check("ar_data_clear", 32'(out_data),  32'h00);
      cyc();
      rst_n     = 1'b1;
      out_ready = 1'b1;
      #1;
      check("ar_restart_ready", 32'(in_ready), 32'b0001);
      cyc();
      check("ar_restart_sel", 32'(out_sel), 32'd0);
      cyc();
      check("ar_next_sel", 32'(out_sel), 32'd1);

      @(negedge clk);
      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: got no end expected end by 20000");
      $fatal(1);
   end

endmodule
